// File: rtl/bank_core_rsp_queue_pkg.sv
// rtl/bank_core_rsp_queue_pkg.sv - shared widths and entry packing for the bank response queue
// Entries are packed {pmask, tid, tag, data}, most significant field first.
package bank_core_rsp_queue_pkg;

  localparam int BYTE_BITS = 8;

  function automatic int word_width(input int word_size);
    return BYTE_BITS * word_size;
  endfunction

  function automatic int reqs_bits(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int entry_width(input int num_ports, input int word_size,
                                     input int num_reqs, input int tag_width);
    return num_ports + num_ports * reqs_bits(num_reqs) + tag_width
         + num_ports * word_width(word_size);
  endfunction

endpackage

// File: rtl/bank_core_rsp_queue_dp_ram.sv
// rtl/bank_core_rsp_queue_dp_ram.sv - one-write one-read storage array with asynchronous read
// The array is intentionally not reset; occupancy is tracked by the queue core.
module bank_core_rsp_queue_dp_ram #(
  parameter int DATAW = 1,
  parameter int SIZE  = 2,
  localparam int ADDRW = $clog2(SIZE)
) (
  input  logic             i_clk,
  input  logic             i_wren,
  input  logic [ADDRW-1:0] i_waddr,
  input  logic [DATAW-1:0] i_wdata,
  input  logic [ADDRW-1:0] i_raddr,
  output logic [DATAW-1:0] o_rdata
);

  logic [DATAW-1:0] r_mem [SIZE];

  always_ff @(posedge i_clk) begin
    if (i_wren) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bank_core_rsp_queue.sv
// rtl/bank_core_rsp_queue.sv - per-bank core-response queue with registered head and almost-full
// The head register is an occupied entry; the RAM holds the count-1 entries behind it.
module bank_core_rsp_queue
  import bank_core_rsp_queue_pkg::*;
#(
  parameter int CACHE_ID       = 0,
  parameter int NUM_REQS       = 4,
  parameter int NUM_PORTS      = 1,
  parameter int WORD_SIZE      = 4,
  parameter int CORE_TAG_WIDTH = 8,
  parameter int QUEUE_SIZE     = 8,
  parameter int ALM_FULL       = QUEUE_SIZE - 2,
  localparam int WORD_WIDTH    = word_width(WORD_SIZE),
  localparam int REQS_BITS     = reqs_bits(NUM_REQS),
  localparam int CNTW          = $clog2(QUEUE_SIZE) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enq_valid,
  input  logic [NUM_PORTS-1:0]            enq_pmask,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] enq_data,
  input  logic [NUM_PORTS*REQS_BITS-1:0]  enq_tid,
  input  logic [CORE_TAG_WIDTH-1:0]       enq_tag,
  output logic                            enq_ready,
  output logic                            alm_full,
  output logic                            rsp_valid,
  output logic [NUM_PORTS-1:0]            rsp_pmask,
  output logic [NUM_PORTS*WORD_WIDTH-1:0] rsp_data,
  output logic [NUM_PORTS*REQS_BITS-1:0]  rsp_tid,
  output logic [CORE_TAG_WIDTH-1:0]       rsp_tag,
  input  logic                            rsp_ready,
  output logic [CNTW-1:0]                 count,
  output logic                            empty,
  output logic                            full
);

  localparam int ADDRW   = $clog2(QUEUE_SIZE);
  localparam int ENTRY_W = entry_width(NUM_PORTS, WORD_SIZE, NUM_REQS, CORE_TAG_WIDTH);
  localparam logic [CNTW-1:0] QSIZE_C = CNTW'(QUEUE_SIZE);
  localparam logic [CNTW-1:0] ALMF_C  = CNTW'(ALM_FULL);

  logic [ADDRW-1:0]   r_rd_ptr;
  logic [ADDRW-1:0]   r_wr_ptr;
  logic [CNTW-1:0]    r_count;
  logic               r_alm_full;
  logic [ENTRY_W-1:0] r_head;

  logic               w_enq_fire;
  logic               w_deq_fire;
  logic               w_bypass;
  logic               w_ram_write;
  logic               w_head_from_ram;
  logic [ENTRY_W-1:0] w_enq_entry;
  logic [ENTRY_W-1:0] w_ram_rdata;
  logic [CNTW-1:0]    w_count_next;

  assign w_enq_entry = {enq_pmask, enq_tid, enq_tag, enq_data};

  assign enq_ready  = (r_count != QSIZE_C);
  assign rsp_valid  = (r_count != '0);
  assign w_enq_fire = enq_valid && enq_ready && (|enq_pmask);
  assign w_deq_fire = rsp_valid && rsp_ready;

  // Enqueue goes straight to the head when no other entry would precede it.
  assign w_bypass        = w_enq_fire && ((r_count == '0) ||
                                          ((r_count == CNTW'(1)) && w_deq_fire));
  assign w_ram_write     = w_enq_fire && !w_bypass;
  assign w_head_from_ram = w_deq_fire && (r_count > CNTW'(1));

  always_comb begin
    w_count_next = r_count;
    if (w_enq_fire && !w_deq_fire) begin
      w_count_next = r_count + CNTW'(1);
    end else if (!w_enq_fire && w_deq_fire) begin
      w_count_next = r_count - CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_alm_full <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_alm_full <= (w_count_next >= ALMF_C);
      if (w_ram_write) begin
        r_wr_ptr <= r_wr_ptr + ADDRW'(1);
      end
      if (w_head_from_ram) begin
        r_rd_ptr <= r_rd_ptr + ADDRW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_bypass) begin
      r_head <= w_enq_entry;
    end else if (w_head_from_ram) begin
      r_head <= w_ram_rdata;
    end
  end

  bank_core_rsp_queue_dp_ram #(
    .DATAW (ENTRY_W),
    .SIZE  (QUEUE_SIZE)
  ) u_ram (
    .i_clk   (clk),
    .i_wren  (w_ram_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_enq_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  assign {rsp_pmask, rsp_tid, rsp_tag, rsp_data} = r_head;

  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == QSIZE_C);
  assign alm_full = r_alm_full;

`ifndef SYNTHESIS
  // A refused enqueue must never grow occupancy; a stalled head must hold still.
  a_blocked_enq: assert property (@(posedge clk) disable iff (reset)
    (enq_valid && !enq_ready) |=> (r_count <= $past(r_count)))
    else $error("bank_core_rsp_queue cache %0d: blocked enqueue grew occupancy", CACHE_ID);

  a_head_stable: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(r_head)))
    else $error("bank_core_rsp_queue cache %0d: head changed while stalled", CACHE_ID);
`endif

endmodule

// File: tb/tb_bank_core_rsp_queue.sv
// tb/tb_bank_core_rsp_queue.sv - randomized scoreboard bench for the bank response queue
module tb_bank_core_rsp_queue;

  localparam int QS  = 8;
  localparam int ALM = 6;

  typedef struct packed {
    logic [0:0]  pmask;
    logic [1:0]  tid;
    logic [7:0]  tag;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enq_valid = 1'b0;
  logic [0:0]  enq_pmask = '0;
  logic [31:0] enq_data = '0;
  logic [1:0]  enq_tid = '0;
  logic [7:0]  enq_tag = '0;
  logic        enq_ready;
  logic        alm_full;
  logic        rsp_valid;
  logic [0:0]  rsp_pmask;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tid;
  logic [7:0]  rsp_tag;
  logic        rsp_ready = 1'b0;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_en = 1'b0;
  ent_t mq[$];

  bank_core_rsp_queue #(
    .CACHE_ID       (0),
    .NUM_REQS       (4),
    .NUM_PORTS      (1),
    .WORD_SIZE      (4),
    .CORE_TAG_WIDTH (8),
    .QUEUE_SIZE     (QS),
    .ALM_FULL       (ALM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_pmask (enq_pmask),
    .enq_data  (enq_data),
    .enq_tid   (enq_tid),
    .enq_tag   (enq_tag),
    .enq_ready (enq_ready),
    .alm_full  (alm_full),
    .rsp_valid (rsp_valid),
    .rsp_pmask (rsp_pmask),
    .rsp_data  (rsp_data),
    .rsp_tid   (rsp_tid),
    .rsp_tag   (rsp_tag),
    .rsp_ready (rsp_ready),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of accepted entries, updated with the pre-edge inputs.
  always @(posedge clk) begin
    bit do_enq;
    bit do_deq;
    if (!reset) begin
      do_deq = (mq.size() > 0) && rsp_ready;
      do_enq = enq_valid && (mq.size() < QS) && (enq_pmask != 0);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back('{enq_pmask, enq_tid, enq_tag, enq_data});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == QS);
      chk("enq_ready", enq_ready, mq.size() != QS);
      chk("alm_full", alm_full, mq.size() >= ALM);
      chk("rsp_valid", rsp_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("rsp_entry", {rsp_pmask, rsp_tid, rsp_tag, rsp_data}, mq[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input bit v, input logic [0:0] pm, input logic [7:0] tag,
                         input logic [31:0] data, input logic [1:0] tid);
    enq_valid = v;
    enq_pmask = pm;
    enq_tag   = tag;
    enq_data  = data;
    enq_tid   = tid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_alm", alm_full, 0);
    chk("rst_rsp_valid", rsp_valid, 0);

    // single entry with one-cycle latency
    rsp_ready = 1'b1;
    set_enq(1, 1'b1, 8'h11, 32'hDEADBEEF, 2'd0);
    tick();
    set_enq(0, 1'b0, 8'h00, 32'h0, 2'd0);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_tag", rsp_tag, 8'h11);
    chk("t1_data", rsp_data, 32'hDEADBEEF);
    chk("t1_pmask", rsp_pmask, 1);
    tick();
    chk("t1_empty", empty, 1);
    chk("t1_count", count, 0);

    // fill to full with the head stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < QS; i++) begin
      set_enq(1, 1'b1, 8'(i), $urandom, 2'($urandom_range(0, 3)));
      tick();
      if (i == ALM - 2) chk("alm_before", alm_full, 0);
      if (i == ALM - 1) chk("alm_after", alm_full, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_ready", enq_ready, 0);
    set_enq(1, 1'b1, 8'h08, 32'h0BAD0BAD, 2'd1);
    tick();
    chk("ninth_count", count, QS);

    // dequeue at full never admits the pending enqueue
    chk("full_head", rsp_tag, 0);
    rsp_ready = 1'b1;
    tick();
    set_enq(0, 1'b0, 8'h00, 32'h0, 2'd0);
    chk("full_deq_count", count, 7);
    for (int t = 1; t < QS; t++) begin
      chk("drain_tag", rsp_tag, t);
      tick();
    end
    chk("drain_empty", empty, 1);

    // preload three, then random traffic across wrap-around
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(1, 1'b1, 8'($urandom), $urandom, 2'($urandom));
      tick();
    end
    set_enq(0, 1'b0, 8'h00, 32'h0, 2'd0);
    chk("pre_count", count, 3);
    for (int c = 0; c < 200; c++) begin
      set_enq($urandom_range(0, 9) < 6, ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1,
              8'($urandom), $urandom, 2'($urandom));
      rsp_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    set_enq(0, 1'b0, 8'h00, 32'h0, 2'd0);
    rsp_ready = 1'b1;
    repeat (QS + 1) tick();
    chk("rand_drained", empty, 1);

    // zero pmask is dropped
    set_enq(1, 1'b0, 8'h33, 32'h33333333, 2'd2);
    tick();
    set_enq(0, 1'b0, 8'h00, 32'h0, 2'd0);
    chk("pm0_count", count, 0);
    chk("pm0_valid", rsp_valid, 0);

    // asynchronous reset with five entries buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_enq(1, 1'b1, 8'(8'h40 + i), $urandom, 2'($urandom));
      tick();
    end
    set_enq(0, 1'b0, 8'h00, 32'h0, 2'd0);
    chk("pre_rst_count", count, 5);
    @(negedge clk);
    #2 reset = 1'b1;
    mq.delete();
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_alm", alm_full, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    set_enq(1, 1'b1, 8'hA5, 32'h12345678, 2'd3);
    tick();
    set_enq(0, 1'b0, 8'h00, 32'h0, 2'd0);
    chk("post_rst_count", count, 1);
    chk("post_rst_tag", rsp_tag, 8'hA5);
    chk("post_rst_data", rsp_data, 32'h12345678);
    rsp_ready = 1'b1;
    tick();
    chk("post_rst_empty", empty, 1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
